serial_parallel_rx: RTL



---
 rtl/phy_pkg.sv | 13 +
 rtl/serial_parallel_rx.sv | 118 +++++++++++
 2 files changed

// File: rtl/phy_pkg.sv
// Shared PHY lane definitions: special characters and the receive-side alignment state encoding.
package phy_pkg;

    localparam logic [7:0] COM_CHAR  = 8'hBC;
    localparam logic [7:0] IDLE_CHAR = 8'h7C;

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        ALIGNING  = 2'd1,
        ACTIVE    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_parallel_rx.sv
// Serial-to-parallel lane receiver: hunts for COM to find byte alignment, confirms it over
// COM_COUNT aligned COMs, then delivers one byte per 8 clk_32f cycles with COM/IDLE stripped.
module serial_parallel_rx #(
    parameter logic [7:0]  COM_CHAR  = phy_pkg::COM_CHAR,
    parameter logic [7:0]  IDLE_CHAR = phy_pkg::IDLE_CHAR,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);
    import phy_pkg::*;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    rx_state_t  state, state_next;
    logic [7:0] sr;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [3:0] com_cnt, com_cnt_next;
    logic [7:0] cand;
    logic       boundary;
    logic       is_com;
    logic       strobe_next;
    logic       valid_next;
    logic [7:0] data_next;
    logic       active_next;

    assign cand     = {sr[6:0], data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_com   = (cand == COM_CHAR);

    // State register; outputs are registered so they change only on the boundary edge.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state       <= UNALIGNED;
            sr          <= 8'h00;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_next;
            sr          <= cand;
            bit_cnt     <= bit_cnt_next;
            com_cnt     <= com_cnt_next;
            data_out    <= data_next;
            valid_out   <= valid_next;
            byte_strobe <= strobe_next;
            active      <= active_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt + 3'd1;
        com_cnt_next = com_cnt;
        case (state)
            UNALIGNED: begin
                bit_cnt_next = bit_cnt;
                if (is_com) begin
                    bit_cnt_next = 3'd0;
                    com_cnt_next = 4'd1;
                    state_next   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGNING;
                end
            end
            ALIGNING: begin
                if (boundary) begin
                    if (!is_com) begin
                        state_next   = UNALIGNED;
                        com_cnt_next = 4'd0;
                    end else if (com_cnt + 4'd1 >= COM_TARGET) begin
                        com_cnt_next = COM_TARGET;
                        state_next   = ACTIVE;
                    end else begin
                        com_cnt_next = com_cnt + 4'd1;
                    end
                end
            end
            ACTIVE: begin
                state_next = ACTIVE;
            end
            default: begin
                state_next = UNALIGNED;
            end
        endcase
    end

    always_comb begin
        strobe_next = 1'b0;
        data_next   = data_out;
        valid_next  = valid_out;
        active_next = (state_next == ACTIVE);
        case (state)
            UNALIGNED: strobe_next = is_com;
            ALIGNING:  strobe_next = boundary;
            ACTIVE: begin
                if (boundary) begin
                    strobe_next = 1'b1;
                    if (is_com || cand == IDLE_CHAR) begin
                        valid_next = 1'b0;
                        data_next  = 8'h00;
                    end else begin
                        valid_next = 1'b1;
                        data_next  = cand;
                    end
                end
            end
            default: strobe_next = 1'b0;
        endcase
    end

endmodule
